// File: rtl/pcie_tx_pkg.sv
// Shared encodings and credit helpers for the VC0 transmit arbiter.
package pcie_tx_pkg;

   typedef enum logic [1:0] {
      CLS_P   = 2'b00,
      CLS_NP  = 2'b01,
      CLS_CPL = 2'b10,
      CLS_INV = 2'b11
   } tlp_cls_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_XFER = 2'b10
   } arb_state_e;

   localparam int HDR_INF_BIT = 8;
   localparam int DAT_INF_BIT = 12;
   localparam int HDR_W       = HDR_INF_BIT + 1;
   localparam int DAT_W       = DAT_INF_BIT + 1;
   localparam int PD_W        = 8;
   localparam int DATA_W      = 16;

   function automatic logic hdr_avail(input logic [HDR_W-1:0] ca);
      return ca[HDR_INF_BIT] | (ca[HDR_INF_BIT-1:0] != '0);
   endfunction

   function automatic logic dat_avail(input logic [DAT_W-1:0] ca,
                                      input logic [PD_W-1:0]  need);
      return ca[DAT_INF_BIT] |
             (ca[DAT_INF_BIT-1:0] >= {{(DAT_INF_BIT-PD_W){1'b0}}, need});
   endfunction

endpackage

// File: rtl/pcie_tx_credit_chk.sv
// Combinational credit check for one requester: does the core advertise
// enough header and data credit for this TLP's class?
module pcie_tx_credit_chk
   import pcie_tx_pkg::*;
(
   input  logic [1:0]       tlp_type,
   input  logic [PD_W-1:0]  need_pd,
   input  logic [HDR_W-1:0] ca_ph,
   input  logic [HDR_W-1:0] ca_nph,
   input  logic [HDR_W-1:0] ca_cplh,
   input  logic [DAT_W-1:0] ca_pd,
   input  logic [DAT_W-1:0] ca_npd,
   input  logic [DAT_W-1:0] ca_cpld,
   output logic             ok
);

   always_comb begin
      ok = 1'b0;
      case (tlp_cls_e'(tlp_type))
         CLS_P:   ok = hdr_avail(ca_ph)   & dat_avail(ca_pd,   need_pd);
         CLS_NP:  ok = hdr_avail(ca_nph)  & dat_avail(ca_npd,  need_pd);
         CLS_CPL: ok = hdr_avail(ca_cplh) & dat_avail(ca_cpld, need_pd);
         default: ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/pcie_tx_arb.sv
// Two-port round-robin arbiter in front of the PCIe core VC0 transmit port,
// with credit gating, tx_req/tx_rdy handshake and a transfer watchdog.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no TLP in flight; arbitrate among credit-eligible requesters
//   ST_REQ  | tx_req raised for the latched owner, waiting for tx_rdy
//   ST_XFER | owner's st/end/data forwarded to the core until end
module pcie_tx_arb
   import pcie_tx_pkg::*;
#(
   parameter int TIMEOUT_W = 10
)
(
   input  logic              pcie_clk,
   input  logic              sys_rst_n,

   input  logic              c0_req,
   input  logic [1:0]        c0_type,
   input  logic [PD_W-1:0]   c0_pd,
   input  logic              c0_st,
   input  logic              c0_end,
   input  logic [DATA_W-1:0] c0_data,
   output logic              c0_gnt,

   input  logic              c1_req,
   input  logic [1:0]        c1_type,
   input  logic [PD_W-1:0]   c1_pd,
   input  logic              c1_st,
   input  logic              c1_end,
   input  logic [DATA_W-1:0] c1_data,
   output logic              c1_gnt,

   output logic              tx_req,
   input  logic              tx_rdy,
   output logic              tx_st,
   output logic              tx_end,
   output logic [DATA_W-1:0] tx_data,

   input  logic [HDR_W-1:0]  tx_ca_ph,
   input  logic [HDR_W-1:0]  tx_ca_nph,
   input  logic [HDR_W-1:0]  tx_ca_cplh,
   input  logic [DAT_W-1:0]  tx_ca_pd,
   input  logic [DAT_W-1:0]  tx_ca_npd,
   input  logic [DAT_W-1:0]  tx_ca_cpld,
   input  logic              tx_ca_p_recheck,
   input  logic              tx_ca_cpl_recheck,

   output logic              busy,
   output logic              owner,
   output logic              err_timeout
);

   arb_state_e           state_q, state_d;
   tlp_cls_e             cls_q, cls_d;
   logic                 owner_q, owner_d;
   logic                 rr_q, rr_d;
   logic                 err_q, err_d;
   logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
   logic [TIMEOUT_W-1:0] wdog_inc;

   logic                 ok0, ok1;
   logic                 elig0, elig1;
   logic                 pick;
   logic                 recheck;
   logic                 wdog_last;
   logic                 own_st, own_end;
   logic [DATA_W-1:0]    own_data;

   pcie_tx_credit_chk u_chk0 (
      .tlp_type (c0_type),
      .need_pd  (c0_pd),
      .ca_ph    (tx_ca_ph),
      .ca_nph   (tx_ca_nph),
      .ca_cplh  (tx_ca_cplh),
      .ca_pd    (tx_ca_pd),
      .ca_npd   (tx_ca_npd),
      .ca_cpld  (tx_ca_cpld),
      .ok       (ok0)
   );

   pcie_tx_credit_chk u_chk1 (
      .tlp_type (c1_type),
      .need_pd  (c1_pd),
      .ca_ph    (tx_ca_ph),
      .ca_nph   (tx_ca_nph),
      .ca_cplh  (tx_ca_cplh),
      .ca_pd    (tx_ca_pd),
      .ca_npd   (tx_ca_npd),
      .ca_cpld  (tx_ca_cpld),
      .ok       (ok1)
   );

   assign elig0 = c0_req & ok0;
   assign elig1 = c1_req & ok1;
   // Contention goes to rr; otherwise whoever is eligible (elig1 alone -> 1).
   assign pick  = (elig0 & elig1) ? rr_q : elig1;

   assign recheck  = (cls_q == CLS_CPL) ? tx_ca_cpl_recheck : tx_ca_p_recheck;
   assign own_st   = owner_q ? c1_st   : c0_st;
   assign own_end  = owner_q ? c1_end  : c0_end;
   assign own_data = owner_q ? c1_data : c0_data;

   // Fires in the cycle the count would step onto all-ones, so the counter
   // never wraps and an XFER lasts at most 2^TIMEOUT_W-1 cycles.
   assign wdog_inc  = wdog_q + 1'b1;
   assign wdog_last = &wdog_inc;

   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      err_d   = err_q;
      wdog_d  = wdog_q;
      tx_req  = 1'b0;
      c0_gnt  = 1'b0;
      c1_gnt  = 1'b0;
      tx_st   = 1'b0;
      tx_end  = 1'b0;
      tx_data = '0;

      case (state_q)
         ST_IDLE: begin
            if (elig0 | elig1) begin
               owner_d = pick;
               cls_d   = tlp_cls_e'(pick ? c1_type : c0_type);
               state_d = ST_REQ;
            end
         end

         ST_REQ: begin
            tx_req = 1'b1;
            if (tx_rdy) begin
               c0_gnt  = ~owner_q;
               c1_gnt  = owner_q;
               wdog_d  = '0;
               state_d = ST_XFER;
            end else if (recheck) begin
               state_d = ST_IDLE;
            end
         end

         ST_XFER: begin
            tx_st   = own_st;
            tx_end  = own_end;
            tx_data = own_data;
            if (own_end) begin
               state_d = ST_IDLE;
               rr_d    = ~owner_q;
            end else if (wdog_last) begin
               state_d = ST_IDLE;
               rr_d    = ~owner_q;
               err_d   = 1'b1;
            end else begin
               wdog_d  = wdog_inc;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
         cls_q   <= CLS_P;
         owner_q <= 1'b0;
         rr_q    <= 1'b0;
         err_q   <= 1'b0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         err_q   <= err_d;
         wdog_q  <= wdog_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign owner       = owner_q;
   assign err_timeout = err_q;

endmodule
